// File: rtl/mult8_pkg.sv
// Shared types, widths and the round-robin pick function for the
// multiplier-sharing arbiter.
package mult8_pkg;

    localparam int MULT_W  = 8;
    localparam int PROD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef logic signed [MULT_W-1:0] opnd_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // One-hot grant on the first set bit of e at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] e,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && e[idx[2:0]]) begin
                    g[idx[2:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/multiply8_signed.sv
// Combinational 8x8 signed multiplier; the single shared array.
module multiply8_signed
    import mult8_pkg::*;
(
    input  opnd_t a,
    input  opnd_t b,
    output prod_t p
);

    prod_t a_x;
    prod_t b_x;

    // Sign-extend both operands so the 16-bit product is exact.
    always_comb begin
        a_x = {{(PROD_W-MULT_W){a[MULT_W-1]}}, a};
        b_x = {{(PROD_W-MULT_W){b[MULT_W-1]}}, b};
        p   = a_x * b_x;
    end

endmodule

// File: rtl/mult8_share_arbiter.sv
// Round-robin arbiter sharing one signed 8x8 multiplier between NREQ
// requesters; operand register S1, result register S2, tagged response.
module mult8_share_arbiter
    import mult8_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   cfg_mask,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output prod_t             rsp_product,
    output logic [15:0]       op_count
);

    logic               s1_valid_q, s1_valid_d;
    opnd_t              s1_a_q, s1_a_d;
    opnd_t              s1_b_q, s1_b_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    prod_t              rsp_product_q, rsp_product_d;
    logic [15:0]        op_count_q, op_count_d;

    logic               adv2;
    logic               can_accept;
    logic               any_hs;
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic [MAX_REQ-1:0] pick_full;
    logic               unused_pick;
    prod_t              mult_p;

    multiply8_signed u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mult_p)
    );

    // Pipeline advance conditions and round-robin grant; no grant in reset.
    always_comb begin
        adv2       = !rsp_valid_q || rsp_ready;
        can_accept = !s1_valid_q || adv2;
        eligible   = req_valid & cfg_mask;
        pick_full  = rr_pick(MAX_REQ'(eligible), 3'(rr_ptr_q), NREQ);
        grant      = (can_accept && rst_n) ? pick_full[NREQ-1:0] : '0;
        any_hs     = |grant;
    end

    assign unused_pick = ^pick_full;

    // Encode the one-hot grant into a requester index.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    // Next state: S2 drains/loads, S1 refills on a grant, pointer rotates.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_id_d       = s1_id_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        op_count_d    = op_count_q;

        if (adv2) begin
            rsp_valid_d   = s1_valid_q;
            rsp_product_d = mult_p;
            rsp_id_d      = s1_id_q;
            s1_valid_d    = 1'b0;
        end

        if (any_hs) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[int'(grant_id)*8 +: 8];
            s1_b_d     = req_b[int'(grant_id)*8 +: 8];
            s1_id_d    = grant_id;
            rr_ptr_d   = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end

        if (rsp_valid_q && rsp_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    // Control and output registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            rr_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            op_count_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            op_count_q    <= op_count_d;
        end
    end

    // S1 operand payload; qualified by s1_valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s1_id_q <= s1_id_d;
    end

    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign op_count    = op_count_q;

endmodule
